// File: rtl/ascii_decimal_parser.sv
// Streams ASCII digits from a byte source and emits one unsigned value per CR/LF-terminated line.
// Malformed or oversized numbers raise a single parse_error pulse, then the rest of the line is dropped.
module ascii_decimal_parser #(
    parameter int VALUE_WIDTH = 32,
    parameter int MAX_DIGITS  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             char_in,
    input  logic                   char_valid,
    output logic                   char_ready,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic                   value_valid,
    input  logic                   value_ready,
    output logic                   parse_error,
    output logic [3:0]             digit_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [VALUE_WIDTH+3:0] TEN        = (VALUE_WIDTH + 4)'(10);
    localparam logic [7:0]             MAX_COUNT  = 8'(MAX_DIGITS);

    state_t                 state_q, state_d;
    logic [VALUE_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]             count_q, count_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic                   value_valid_q, value_valid_d;
    logic                   parse_error_q, parse_error_d;

    logic                   is_digit;
    logic                   is_term;
    logic                   take;
    logic                   overflow;
    logic [3:0]             digit;
    logic [VALUE_WIDTH+3:0] next_acc;

    always_comb begin
        is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
        is_term  = (char_in == 8'h0D) || (char_in == 8'h0A);
        // Low nibble of an ASCII digit equals char_in - 0x30.
        digit    = char_in[3:0];
        take     = char_valid && (state_q != HOLD);
        next_acc = ({4'b0000, acc_q} * TEN) + {{VALUE_WIDTH{1'b0}}, digit};
        overflow = (next_acc[VALUE_WIDTH+3:VALUE_WIDTH] != 4'd0) || (count_q >= MAX_COUNT);
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        count_d       = count_q;
        value_d       = value_q;
        value_valid_d = value_valid_q;
        parse_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (take && is_digit) begin
                    acc_d   = {{(VALUE_WIDTH-4){1'b0}}, digit};
                    count_d = 8'd1;
                    state_d = ACCUM;
                end else if (take && !is_term) begin
                    parse_error_d = 1'b1;
                    state_d       = FLUSH;
                end
            end
            ACCUM: begin
                if (take) begin
                    if (is_digit && !overflow) begin
                        acc_d   = next_acc[VALUE_WIDTH-1:0];
                        count_d = count_q + 8'd1;
                    end else if (is_term) begin
                        value_d       = acc_q;
                        value_valid_d = 1'b1;
                        state_d       = HOLD;
                    end else begin
                        // Rejected number: acc keeps its last good value, count shows 0 while flushing.
                        parse_error_d = 1'b1;
                        count_d       = 8'd0;
                        state_d       = FLUSH;
                    end
                end
            end
            HOLD: begin
                if (value_ready) begin
                    value_valid_d = 1'b0;
                    acc_d         = '0;
                    count_d       = 8'd0;
                    state_d       = IDLE;
                end
            end
            FLUSH: begin
                if (take && is_term) begin
                    acc_d   = '0;
                    count_d = 8'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            count_q       <= 8'd0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            parse_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            parse_error_q <= parse_error_d;
        end
    end

    assign char_ready  = (state_q != HOLD);
    assign value_out   = value_q;
    assign value_valid = value_valid_q;
    assign parse_error = parse_error_q;
    assign digit_count = (count_q > 8'd15) ? 4'hF : count_q[3:0];

endmodule

// File: doc/ascii_decimal_parser.md
ASCII_DECIMAL_PARSER -- requirements
Module: ascii_decimal_parser

Interface
REQ-001 Parameter VALUE_WIDTH, default 32: width of the parsed unsigned result.
REQ-002 Parameter MAX_DIGITS, default 10: maximum accepted digit count per number.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 char_in  input  8  ASCII character from the byte source (UART RX path).
REQ-006 char_valid  input  1  char_in is valid this cycle.
REQ-007 char_ready  output  1  parser accepts char_in this cycle; a transfer occurs when char_valid & char_ready.
REQ-008 value_out  output  VALUE_WIDTH  parsed unsigned value.
REQ-009 value_valid  output  1  value_out is valid; held until accepted.
REQ-010 value_ready  input  1  consumer accepts value_out; a transfer occurs when value_valid & value_ready.
REQ-011 parse_error  output  1  one-cycle pulse when a number is rejected.
REQ-012 digit_count  output  4  digits accumulated in the current number, saturating at 15.

Function
REQ-013 Digit decode SHALL be: digit = char_in - 0x30; a character is a digit if and only if 0x30 <= char_in <= 0x39.
REQ-014 A terminator SHALL be CR (0x0D) or LF (0x0A); every other non-digit SHALL be an illegal character.
REQ-015 The state machine SHALL have four states: IDLE, ACCUM, HOLD, FLUSH.
REQ-016 IDLE with a digit transfer: acc = digit, count = 1, go to ACCUM.
REQ-017 IDLE with a terminator transfer: no output, no error, stay in IDLE (empty lines ignored).
REQ-018 IDLE or ACCUM with an illegal-character transfer: pulse parse_error the next cycle, go to FLUSH.
REQ-019 ACCUM with a digit transfer: acc = acc*10 + digit, computed in VALUE_WIDTH+4 bits, count += 1.
REQ-020 ACCUM overflow: if the product or sum exceeds 2^VALUE_WIDTH-1, or count would exceed MAX_DIGITS, pulse parse_error and go to FLUSH; acc is not updated.
REQ-021 ACCUM with a terminator transfer: value_out = acc, assert value_valid the next cycle, go to HOLD.
REQ-022 HOLD: char_ready = 0; value_valid and value_out stay stable until value_ready = 1.
REQ-023 HOLD with value_ready = 1: deassert value_valid the next cycle, clear acc and count, go to IDLE.
REQ-024 FLUSH: char_ready = 1; discard all characters; on a terminator transfer, clear acc and count and go to IDLE.
REQ-025 char_ready SHALL be 1 in IDLE, ACCUM and FLUSH, and 0 in HOLD.
REQ-026 Latency: the terminator transfer in cycle N gives value_valid = 1 in cycle N+1.
REQ-027 Throughput: one character per cycle; back-to-back numbers are limited only by the HOLD handshake.
REQ-028 parse_error SHALL be exactly one cycle wide for each rejected number, never in HOLD, and never repeated while in FLUSH.
REQ-029 digit_count SHALL reflect the current count: 0 in IDLE and FLUSH, unchanged during HOLD.
REQ-030 When char_valid = 0, state and outputs SHALL hold, except for the HOLD handshake and the parse_error pulse clearing.

Reset
REQ-031 reset = 1 at a rising edge SHALL force IDLE, acc = 0, count = 0, value_out = 0, value_valid = 0, parse_error = 0 and digit_count = 0; char_ready = 1 from the next cycle.
REQ-032 Reset has priority over every transfer in the same cycle; a number pending in HOLD, or a partial number, SHALL be discarded without a pulse.

Verification
REQ-033 "1","2","3",CR with value_ready = 1 -> value_valid one cycle after CR, value_out = 123, no parse_error.
REQ-034 "4","2",LF with value_ready = 0 for 5 cycles, while char_valid stays high with "7" -> char_ready = 0, value_out = 42 stable; after acceptance, "7" is taken as the first digit of the next number.
REQ-035 "4294967295",CR -> value_out = 0xFFFFFFFF; "4294967296",CR -> parse_error pulse at the final "6", no value_valid.
REQ-036 "1","A","5",CR,"9",CR -> one parse_error pulse after "A", then value_out = 9.
REQ-037 CR,LF,CR -> no value_valid and no parse_error; digit_count stays 0.
REQ-038 reset asserted during ACCUM after "5","5", then "3",CR -> value_out = 3.
